// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one combinational multiplier among requesters.
// Result is returned through a one-entry output register tagged with the winner id.
module mul_share_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 12,
  parameter int B_WIDTH  = 14,
  parameter int P_WIDTH  = 26,
  parameter int ID_WIDTH = 2
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]  req_b,
  output logic [A_WIDTH-1:0]          mul_din0,
  output logic [B_WIDTH-1:0]          mul_din1,
  input  logic [P_WIDTH-1:0]          mul_dout,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [P_WIDTH-1:0]          rsp_p,
  output logic [ID_WIDTH-1:0]         rsp_id,
  output logic [31:0]                 busy_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] win;
  logic [ID_WIDTH-1:0] idx;
  logic [ID_WIDTH-1:0] nxt_ptr;
  logic                found;
  logic                grant;
  logic                can_accept;

  assign can_accept = (state == EMPTY) || rsp_ready;
  assign rsp_valid  = (state == FULL);

  // Search from rr_ptr upward, wrapping; first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    grant   = found && can_accept && ap_rst_n;
    nxt_ptr = ID_WIDTH'((int'(win) + 1) % NUM_REQ);
  end

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    if (grant) begin
      req_ready[win] = 1'b1;
      mul_din0 = req_a[int'(win)*A_WIDTH +: A_WIDTH];
      mul_din1 = req_b[int'(win)*B_WIDTH +: B_WIDTH];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= EMPTY;
      rr_ptr   <= '0;
      rsp_p    <= '0;
      rsp_id   <= '0;
      busy_cnt <= '0;
    end else begin
      if (grant) begin
        state  <= FULL;
        rsp_p  <= mul_dout;
        rsp_id <= win;
        rr_ptr <= nxt_ptr;
        if (busy_cnt != 32'hFFFF_FFFF)
          busy_cnt <= busy_cnt + 32'd1;
      end else if (rsp_ready) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter.
// Directed scenarios plus random traffic against a round-robin reference model.
module tb_mul_share_arbiter;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int BW = 14;
  localparam int PW = 26;
  localparam int IW = 2;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [AW-1:0]   mul_din0;
  logic [BW-1:0]   mul_din1;
  logic [PW-1:0]   mul_dout;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [PW-1:0]   rsp_p;
  logic [IW-1:0]   rsp_id;
  logic [31:0]     busy_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_ptr;
  bit          m_full;
  logic [PW-1:0] m_p;
  int          m_id;
  longint      m_busy;

  int          e_win;
  logic [N-1:0]  e_ready;
  logic [AW-1:0] e_a;
  logic [BW-1:0] e_b;

  always #5 ap_clk = ~ap_clk;

  // The shared DSP: plain combinational multiply.
  assign mul_dout = PW'(mul_din0) * PW'(mul_din1);

  mul_share_arbiter #(
    .NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW),
    .P_WIDTH(PW), .ID_WIDTH(IW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_din0(mul_din0), .mul_din1(mul_din1),
    .mul_dout(mul_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p), .rsp_id(rsp_id),
    .busy_cnt(busy_cnt)
  );

  function automatic void model_reset();
    m_ptr  = 0;
    m_full = 0;
    m_p    = '0;
    m_id   = 0;
    m_busy = 0;
  endfunction

  function automatic void predict();
    e_win   = -1;
    e_ready = '0;
    e_a     = '0;
    e_b     = '0;
    if (!m_full || rsp_ready)
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (e_win < 0 && req_valid[i]) e_win = i;
      end
    if (e_win >= 0) begin
      e_ready[e_win] = 1'b1;
      e_a = req_a[e_win*AW +: AW];
      e_b = req_b[e_win*BW +: BW];
    end
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                       input logic [N*BW-1:0] b, input logic r);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = r;
    #1;
    predict();
  endtask

  task automatic tick();
    @(posedge ap_clk);
    if (e_win >= 0) begin
      m_full = 1;
      m_p    = PW'(e_a) * PW'(e_b);
      m_id   = e_win;
      m_ptr  = (e_win + 1) % N;
      if (m_busy < 64'hFFFF_FFFF) m_busy++;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
    @(negedge ap_clk);
  endtask

  task automatic apply_reset();
    ap_rst_n  = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    model_reset();
    ap_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ap_rst_n  = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_a     = '1;
    req_b     = '1;
    @(negedge ap_clk);
    @(negedge ap_clk);
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    n_checks++;
    if ({rsp_valid, rsp_p, rsp_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: got v=%b p=%0h id=%0d want 0",
               rsp_valid, rsp_p, rsp_id);
    end
    n_checks++;
    if (busy_cnt !== 32'd0 || mul_din0 !== '0 || mul_din1 !== '0) begin
      n_fail++;
      $display("FAIL reset_misc: got busy=%0d d0=%0h d1=%0h want 0",
               busy_cnt, mul_din0, mul_din1);
    end
    req_valid = '0;
    model_reset();
    ap_rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle: got ready=%b v=%b want 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_basic();
    logic [N*AW-1:0] a;
    logic [N*BW-1:0] b;
    a = '0;
    b = '0;
    a[2*AW +: AW] = 12'd3;
    b[2*BW +: BW] = 14'd5;
    drive(4'b0100, a, b, 1'b1);
    n_checks++;
    if (req_ready !== 4'b0100 || mul_din0 !== 12'd3 || mul_din1 !== 14'd5) begin
      n_fail++;
      $display("FAIL basic_grant: got ready=%b d0=%0d d1=%0d want 0100 3 5",
               req_ready, mul_din0, mul_din1);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_p !== 26'd15 || rsp_id !== 2'd2
        || busy_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL basic_rsp: got v=%b p=%0d id=%0d busy=%0d want 1 15 2 1",
               rsp_valid, rsp_p, rsp_id, busy_cnt);
    end
    drive(4'b0000, a, b, 1'b1);
    n_checks++;
    if (req_ready !== 4'b0000 || mul_din0 !== '0 || mul_din1 !== '0) begin
      n_fail++;
      $display("FAIL basic_quiet: got ready=%b d0=%0h d1=%0h want 0",
               req_ready, mul_din0, mul_din1);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_p !== 26'd15 || rsp_id !== 2'd2) begin
      n_fail++;
      $display("FAIL basic_drain: got v=%b p=%0d id=%0d want 0 15 2",
               rsp_valid, rsp_p, rsp_id);
    end
  endtask

  task automatic test_fairness();
    logic [N*AW-1:0] a;
    logic [N*BW-1:0] b;
    int ord[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < N; i++) begin
      a[i*AW +: AW] = AW'(i + 1);
      b[i*BW +: BW] = BW'(10);
    end
    for (int j = 0; j < 5; j++) begin
      drive('1, a, b, 1'b1);
      n_checks++;
      if (req_ready !== N'(1 << ord[j])) begin
        n_fail++;
        $display("FAIL fair_ready[%0d]: got %b want %b",
                 j, req_ready, N'(1 << ord[j]));
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_p !== PW'((ord[j] + 1) * 10)
          || rsp_id !== IW'(ord[j])) begin
        n_fail++;
        $display("FAIL fair_rsp[%0d]: got v=%b p=%0d id=%0d want 1 %0d %0d",
                 j, rsp_valid, rsp_p, rsp_id, (ord[j] + 1) * 10, ord[j]);
      end
    end
    n_checks++;
    if (busy_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL fair_busy: got %0d want 5", busy_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [N*AW-1:0] a;
    logic [N*BW-1:0] b;
    for (int i = 0; i < N; i++) begin
      a[i*AW +: AW] = AW'(i + 1);
      b[i*BW +: BW] = BW'(10);
    end
    for (int j = 0; j < 5; j++) begin
      drive('1, a, b, 1'b0);
      n_checks++;
      if (req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_ready[%0d]: got %b want 0000", j, req_ready);
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_p !== 26'd10 || rsp_id !== 2'd0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b p=%0d id=%0d want 1 10 0",
                 j, rsp_valid, rsp_p, rsp_id);
      end
    end
    drive('1, a, b, 1'b1);
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_refill: got %b want 0010", req_ready);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_p !== 26'd20 || rsp_id !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_next: got v=%b p=%0d id=%0d want 1 20 1",
               rsp_valid, rsp_p, rsp_id);
    end
  endtask

  task automatic test_max();
    drive(4'b0001, '1, '1, 1'b1);
    n_checks++;
    if (mul_din0 !== 12'hFFF || mul_din1 !== 14'h3FFF) begin
      n_fail++;
      $display("FAIL max_din: got %0h %0h want fff 3fff", mul_din0, mul_din1);
    end
    tick();
    n_checks++;
    if (rsp_p !== 26'h3FFB001 || rsp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL max_p: got p=%0h id=%0d want 3ffb001 0", rsp_p, rsp_id);
    end
  endtask

  task automatic test_skip();
    apply_reset();
    drive(4'b0001, '1, '1, 1'b1);
    tick();
    drive(4'b0001, '1, '1, 1'b1);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL skip_wrap: got %b want 0001", req_ready);
    end
    tick();
    drive(4'b0011, '1, '1, 1'b1);
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL skip_ptr: got %b want 0010", req_ready);
    end
    tick();
    n_checks++;
    if (rsp_id !== 2'd1 || busy_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL skip_rsp: got id=%0d busy=%0d want 1 3", rsp_id, busy_cnt);
    end
  endtask

  task automatic test_async_reset();
    drive('1, '1, '1, 1'b0);
    tick();
    #2;
    ap_rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || busy_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL async_rst: got v=%b ready=%b busy=%0d want 0 0000 0",
               rsp_valid, req_ready, busy_cnt);
    end
    @(negedge ap_clk);
    model_reset();
    ap_rst_n = 1'b1;
    drive(4'b1010, '1, '1, 1'b1);
    n_checks++;
    if (req_ready !== 4'b0010 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rearb: got ready=%b v=%b want 0010 0",
               req_ready, rsp_valid);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
      n_fail++;
      $display("FAIL async_rsp: got v=%b id=%0d want 1 1", rsp_valid, rsp_id);
    end
  endtask

  task automatic test_random();
    logic [N-1:0]    v;
    logic [N*AW-1:0] a;
    logic [N*BW-1:0] b;
    logic            r;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      v = N'($urandom);
      a = (N*AW)'({$urandom(), $urandom()});
      b = (N*BW)'({$urandom(), $urandom()});
      if ($urandom_range(0, 7) == 0) begin
        a = '1;
        b = '1;
      end
      r = ($urandom_range(0, 3) != 0);
      drive(v, a, b, r);
      n_checks++;
      if (req_ready !== e_ready || mul_din0 !== e_a || mul_din1 !== e_b) begin
        n_fail++;
        $display("FAIL rnd_grant[%0d]: got %b %0h %0h want %b %0h %0h",
                 c, req_ready, mul_din0, mul_din1, e_ready, e_a, e_b);
      end
      tick();
      n_checks++;
      if (rsp_valid !== m_full || rsp_p !== m_p || rsp_id !== IW'(m_id)
          || busy_cnt !== m_busy[31:0]) begin
        n_fail++;
        $display("FAIL rnd_rsp[%0d]: got %b %0h %0d %0d want %b %0h %0d %0d",
                 c, rsp_valid, rsp_p, rsp_id, busy_cnt,
                 m_full, m_p, m_id, m_busy);
      end
    end
  endtask

  initial begin
    ap_rst_n  = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_fairness();
    test_backpressure();
    test_max();
    test_skip();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
